mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencing controller and two-port arbiter for the single-ported 16-bit CPU memory. It accepts instruction-fetch requests and data load/store requests over independent req/ack handshakes. It grants one requester at a time using round-robin, and drives the memory's read/write/push strobes in the mandatory two-step read (latch, then push) and one-step write order. It sits between the CPU core's fetch and load/store units and the memory block, and owns the memory-side control signals and the write-data driver on the shared data bus.

## Interface
- No parameters; data and address widths are fixed at 16 bits.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_ack
- if_addr  in  16  fetch address
- if_ack  out  1  one-cycle pulse: fetch complete, if_data valid
- if_data  out  16  fetched word; held until next fetch completes
- dm_req  in  1  data request; level, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  16  data address
- dm_wdata  in  16  store data
- dm_ack  out  1  one-cycle pulse: data access complete
- dm_rdata  out  16  loaded word; held until next load completes
- mem_i_read, mem_d_read, mem_d_write  out  1 each  memory strobes
- mem_i_push, mem_d_push  out  1 each  memory bus-drive enables
- mem_i_addr, mem_d_addr  out  16 each  memory addresses
- mem_bus_in  in  16  data bus value as seen by the arbiter
- mem_bus_out  out  16  write data for the bus
- mem_bus_oe  out  1  arbiter drives the bus; top level applies the tristate

## Operation
- States: IDLE, I_READ, I_PUSH, D_READ, D_PUSH, D_WRITE.
- IDLE arbitration:
  - If only one req is high, grant it.
  - If both are high, grant the port not granted last (last_grant register).
  - The granted port's address and, for a store, its write data are latched into internal registers at the grant edge.
  - The latched values drive mem_*_addr and mem_bus_out for the whole transaction. Requester inputs are ignored after the grant.
- Fetch path: IDLE → I_READ → I_PUSH → IDLE.
  - I_READ asserts mem_i_read.
  - I_PUSH asserts mem_i_push. mem_bus_in is captured into if_data at the edge leaving I_PUSH.
- Load path (dm_we=0): IDLE → D_READ → D_PUSH → IDLE. Uses mem_d_read and mem_d_push; captures into dm_rdata.
- Store path (dm_we=1): IDLE → D_WRITE → IDLE.
  - D_WRITE asserts mem_d_write and mem_bus_oe, with mem_bus_out equal to the latched wdata.
- Ack: if_ack or dm_ack is registered high for exactly the one IDLE cycle after the transaction's last state.
- last_grant updates at each grant. After reset last_grant = D, so the instruction port wins the first tie.
- A req still high during its own ack cycle is treated as a new request and may be granted in that same IDLE cycle. Requesters wanting a single access must drop req in the ack cycle.
- Exclusivity invariants (checked by assertion):
  - At most one of the five memory strobes is high in any cycle.
  - mem_bus_oe is never high together with either push signal.
  - All strobes are low in IDLE.

## Timing
- Reset values: state IDLE, all strobes 0, mem_bus_oe 0, acks 0, if_data/dm_rdata/addresses/mem_bus_out 0, last_grant = D.
- Read latency, with the grant at edge 0:
  - READ strobe is high in cycle 1.
  - PUSH is high in cycle 2.
  - ack and data are valid in cycle 3.
  - Back-to-back reads from one port issue every 3 cycles.
- Store latency:
  - D_WRITE is high in cycle 1; ack in cycle 2.
  - Back-to-back stores issue every 2 cycles.
- Both ports held high continuously alternate I, D, I, D… with no idle gap beyond the ack cycle.
- Reset asserted mid-transaction immediately returns all outputs to reset values. The memory action for the aborted transaction is undefined, and no ack is ever produced for it.
- Address wrap: addresses pass through unmodified. The memory decodes its own range; the arbiter performs no arithmetic.
- Req changes while busy are not seen until the next IDLE cycle.

## Test plan
- Single fetch: preload mem[16]=0xA000, pulse-hold if_req with if_addr=16. Required:
  - mem_i_read in cycle 1, mem_i_push in cycle 2.
  - if_ack in cycle 3 with if_data=0xA000.
  - No other strobes at any point.
- Store then load: store dm_addr=0x0020, dm_wdata=0x1234. Required:
  - mem_d_write with mem_bus_oe high in cycle 1, dm_ack in cycle 2.
  - A following load of 0x0020 returns dm_rdata=0x1234 with dm_ack 3 cycles after its grant.
- Contention: assert if_req and dm_req together from reset and hold both for 12 cycles. Required:
  - Grant order I, D, I, D.
  - Acks alternate if_ack and dm_ack, with if_ack first.
- Back-to-back: hold if_req high through 3 acks at addresses 16/17/18. Required: acks at cycles 3, 6, 9, each with the correct word.
- Reset mid-op: assert rst during D_PUSH. Required:
  - All outputs 0 immediately.
  - No dm_ack after reset releases.
  - The next request completes normally.
- Invariant soak: random req/we/addr for 10k cycles with a memory model. Required:
  - The exclusivity assertions never fire.
  - Every req eventually receives an ack, with no starvation over any 2 consecutive grants.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and data load/store for a single-ported
// memory; sequences the two-step read (latch, push) and the one-step write.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_data,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_ack,
  output logic [15:0] dm_rdata,
  output logic        mem_i_read,
  output logic        mem_d_read,
  output logic        mem_d_write,
  output logic        mem_i_push,
  output logic        mem_d_push,
  output logic [15:0] mem_i_addr,
  output logic [15:0] mem_d_addr,
  input  logic [15:0] mem_bus_in,
  output logic [15:0] mem_bus_out,
  output logic        mem_bus_oe
);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    I_PUSH,
    D_READ,
    D_PUSH,
    D_WRITE
  } state_t;

  state_t state_reg;
  logic   last_grant_d_reg;
  logic   grant_i;
  logic   grant_d;

  // On a tie the port that did not win last time gets the grant.
  assign grant_i = if_req && (!dm_req || last_grant_d_reg);
  assign grant_d = dm_req && !grant_i;

  // Strobes and acks are registered one cycle ahead of the state they belong to,
  // so each output lines up exactly with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      last_grant_d_reg <= 1'b1;
      mem_i_read       <= 1'b0;
      mem_i_push       <= 1'b0;
      mem_d_read       <= 1'b0;
      mem_d_push       <= 1'b0;
      mem_d_write      <= 1'b0;
      mem_bus_oe       <= 1'b0;
      if_ack           <= 1'b0;
      dm_ack           <= 1'b0;
      if_data          <= 16'h0000;
      dm_rdata         <= 16'h0000;
      mem_i_addr       <= 16'h0000;
      mem_d_addr       <= 16'h0000;
      mem_bus_out      <= 16'h0000;
    end else begin
      mem_i_read  <= 1'b0;
      mem_i_push  <= 1'b0;
      mem_d_read  <= 1'b0;
      mem_d_push  <= 1'b0;
      mem_d_write <= 1'b0;
      mem_bus_oe  <= 1'b0;
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (grant_i) begin
            state_reg        <= I_READ;
            mem_i_read       <= 1'b1;
            mem_i_addr       <= if_addr;
            last_grant_d_reg <= 1'b0;
          end else if (grant_d) begin
            mem_d_addr       <= dm_addr;
            last_grant_d_reg <= 1'b1;
            if (dm_we) begin
              state_reg   <= D_WRITE;
              mem_d_write <= 1'b1;
              mem_bus_oe  <= 1'b1;
              mem_bus_out <= dm_wdata;
            end else begin
              state_reg  <= D_READ;
              mem_d_read <= 1'b1;
            end
          end
        end
        I_READ: begin
          state_reg  <= I_PUSH;
          mem_i_push <= 1'b1;
        end
        I_PUSH: begin
          state_reg <= IDLE;
          if_data   <= mem_bus_in;
          if_ack    <= 1'b1;
        end
        D_READ: begin
          state_reg  <= D_PUSH;
          mem_d_push <= 1'b1;
        end
        D_PUSH: begin
          state_reg <= IDLE;
          dm_rdata  <= mem_bus_in;
          dm_ack    <= 1'b1;
        end
        D_WRITE: begin
          state_reg <= IDLE;
          dm_ack    <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random-soak bench for mem_arbiter with a small two-step-read memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_data;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        mem_i_read, mem_d_read, mem_d_write, mem_i_push, mem_d_push;
  logic [15:0] mem_i_addr, mem_d_addr;
  logic [15:0] mem_bus_in, mem_bus_out;
  logic        mem_bus_oe;

  int compared;
  int mismatched;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .if_data     (if_data),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .mem_i_read  (mem_i_read),
    .mem_d_read  (mem_d_read),
    .mem_d_write (mem_d_write),
    .mem_i_push  (mem_i_push),
    .mem_d_push  (mem_d_push),
    .mem_i_addr  (mem_i_addr),
    .mem_d_addr  (mem_d_addr),
    .mem_bus_in  (mem_bus_in),
    .mem_bus_out (mem_bus_out),
    .mem_bus_oe  (mem_bus_oe)
  );

  always #5 clk = ~clk;

  // Memory model: READ latches the word, PUSH drives it, WRITE stores the bus value.
  logic [15:0] mem [256];
  logic [15:0] lat;
  logic        init_req;
  logic [15:0] ref_mem [256];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h9FF0 + 16'(i);
    end else begin
      if (mem_i_read) lat <= mem[mem_i_addr[7:0]];
      else if (mem_d_read) lat <= mem[mem_d_addr[7:0]];
      if (mem_d_write) mem[mem_d_addr[7:0]] <= mem_bus_out;
    end
  end

  assign mem_bus_in = (mem_i_push || mem_d_push) ? lat : (mem_bus_oe ? mem_bus_out : 16'h0000);

  wire [4:0] strb5 = {mem_i_read, mem_i_push, mem_d_read, mem_d_push, mem_d_write};
  wire [5:0] strb6 = {strb5, mem_bus_oe};

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IRD  = 6'b100000;
  localparam logic [5:0] S_IPS  = 6'b010000;
  localparam logic [5:0] S_DRD  = 6'b001000;
  localparam logic [5:0] S_DPS  = 6'b000100;
  localparam logic [5:0] S_DWR  = 6'b000011;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("inv_onehot", 128'(($countones(strb5) <= 1)), 128'd1);
    chk("inv_oe_push", 128'(mem_bus_oe & (mem_i_push | mem_d_push)), 128'd0);
    if (if_ack || dm_ack) chk("inv_idle_strobes", 128'(strb6), 128'(S_NONE));
  endtask

  int if_wait, dm_wait;
  logic [5:0] exp_s;
  logic [1:0] exp_a;

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; init_req = 1'b1;
    if_req = 1'b0; if_addr = 16'h0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h9FF0 + 16'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 128'(strb6), 128'(S_NONE));
    chk("rst_acks", 128'({if_ack, dm_ack}), 128'd0);
    chk("rst_data", 128'({if_data, dm_rdata}), 128'd0);
    chk("rst_addr", 128'({mem_i_addr, mem_d_addr, mem_bus_out}), 128'd0);
    rst = 1'b0; init_req = 1'b0;
    step();

    // Single fetch; the address change after grant must be ignored.
    if_addr = 16'd16; if_req = 1'b1;
    step(); $display("fetch cycle1 strobes=%b", strb6);
    chk("f1_read", 128'(strb6), 128'(S_IRD));
    chk("f1_addr", 128'(mem_i_addr), 128'd16);
    if_addr = 16'h0099;
    step(); $display("fetch cycle2 strobes=%b", strb6);
    chk("f1_push", 128'(strb6), 128'(S_IPS));
    chk("f1_addr_held", 128'(mem_i_addr), 128'd16);
    step(); $display("fetch cycle3 ack=%b data=%h", if_ack, if_data);
    chk("f1_ack", 128'({if_ack, dm_ack}), 128'b10);
    chk("f1_data", 128'(if_data), 128'hA000);
    if_req = 1'b0;
    step();
    chk("f1_no_reack", 128'({if_ack, strb6}), 128'd0);

    // Store then load of the same address.
    dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234; dm_req = 1'b1;
    step(); $display("store cycle1 strobes=%b bus=%h", strb6, mem_bus_out);
    chk("st_write", 128'(strb6), 128'(S_DWR));
    chk("st_bus", 128'(mem_bus_out), 128'h1234);
    chk("st_addr", 128'(mem_d_addr), 128'h0020);
    step(); $display("store cycle2 ack=%b", dm_ack);
    chk("st_ack", 128'({if_ack, dm_ack}), 128'b01);
    ref_mem[8'h20] = 16'h1234;
    dm_we = 1'b0; dm_wdata = 16'h0;
    step();
    chk("ld_read", 128'(strb6), 128'(S_DRD));
    step();
    chk("ld_push", 128'(strb6), 128'(S_DPS));
    step(); $display("load ack=%b rdata=%h", dm_ack, dm_rdata);
    chk("ld_ack", 128'({if_ack, dm_ack}), 128'b01);
    chk("ld_data", 128'(dm_rdata), 128'h1234);
    dm_req = 1'b0;
    step();

    // Contention straight from reset: I wins the first tie, then strict alternation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    if_addr = 16'd17; dm_addr = 16'd18; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_s = (c == 1 || c == 7) ? S_IRD : (c == 2 || c == 8) ? S_IPS :
              (c == 4 || c == 10) ? S_DRD : (c == 5 || c == 11) ? S_DPS : S_NONE;
      exp_a = (c % 6 == 3) ? 2'b10 : (c % 6 == 0) ? 2'b01 : 2'b00;
      $display("contention cycle %0d strobes=%b acks=%b", c, strb6, {if_ack, dm_ack});
      chk("cont_strobes", 128'(strb6), 128'(exp_s));
      chk("cont_acks", 128'({if_ack, dm_ack}), 128'(exp_a));
      if (c == 3 || c == 9) chk("cont_idata", 128'(if_data), 128'hA001);
      if (c == 6 || c == 12) chk("cont_ddata", 128'(dm_rdata), 128'hA002);
    end
    if_req = 1'b0; dm_req = 1'b0;
    step();
    chk("cont_quiet", 128'(strb6), 128'(S_NONE));

    // Back-to-back fetches at 16/17/18.
    if_addr = 16'd16; if_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      $display("b2b cycle %0d ack=%b data=%h", c, if_ack, if_data);
      chk("b2b_ack", 128'(if_ack), 128'((c % 3) == 0));
      chk("b2b_read", 128'(mem_i_read), 128'((c % 3) == 1));
      if (c % 3 == 0) begin
        chk("b2b_data", 128'(if_data), 128'(16'hA000 + 16'(c / 3 - 1)));
        if_addr = 16'd16 + 16'(c / 3);
      end
    end
    if_req = 1'b0;
    step();
    chk("b2b_quiet", 128'(strb6), 128'(S_NONE));

    // Reset during D_PUSH.
    dm_we = 1'b0; dm_addr = 16'd16; dm_req = 1'b1;
    step();
    chk("rm_read", 128'(strb6), 128'(S_DRD));
    step();
    chk("rm_push", 128'(strb6), 128'(S_DPS));
    dm_req = 1'b0;
    rst = 1'b1;
    #1;
    $display("reset mid-op strobes=%b if_data=%h", strb6, if_data);
    chk("rm_strobes", 128'(strb6), 128'(S_NONE));
    chk("rm_acks", 128'({if_ack, dm_ack}), 128'd0);
    chk("rm_data", 128'({if_data, dm_rdata}), 128'd0);
    chk("rm_addr", 128'({mem_i_addr, mem_d_addr, mem_bus_out}), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rm_no_ack", 128'(dm_ack), 128'd0);
    end
    if_addr = 16'd17; if_req = 1'b1;
    step(); step(); step();
    $display("post-reset fetch ack=%b data=%h", if_ack, if_data);
    chk("rm_next_ack", 128'({if_ack, dm_ack}), 128'b10);
    chk("rm_next_data", 128'(if_data), 128'hA001);
    if_req = 1'b0;
    step();

    // Random soak with a bench-side reference memory.
    if_wait = 0; dm_wait = 0;
    for (int n = 0; n < 10000; n++) begin
      step();
      if (if_ack) begin
        chk("soak_if_pending", 128'(if_req), 128'd1);
        chk("soak_if_data", 128'(if_data), 128'(ref_mem[if_addr[7:0]]));
        if_req = 1'b0;
      end else if (if_req) begin
        if_wait++;
      end
      if (dm_ack) begin
        chk("soak_dm_pending", 128'(dm_req), 128'd1);
        if (dm_we) ref_mem[dm_addr[7:0]] = dm_wdata;
        else chk("soak_dm_data", 128'(dm_rdata), 128'(ref_mem[dm_addr[7:0]]));
        dm_req = 1'b0;
      end else if (dm_req) begin
        dm_wait++;
      end
      chk("soak_if_wait", 128'(if_wait <= 5), 128'd1);
      chk("soak_dm_wait", 128'(dm_wait <= 5), 128'd1);
      if (!if_req && $urandom_range(0, 3) != 0) begin
        if_req = 1'b1; if_addr = 16'($urandom_range(0, 255)); if_wait = 0;
      end
      if (!dm_req && $urandom_range(0, 3) != 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 255)); dm_wdata = 16'($urandom_range(0, 65535));
        dm_wait = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
